// File: rtl/am_envelope_demod.sv
// AM envelope demodulator: full-wave rectifier, boxcar integrate-and-dump decimator.
// Optional output DC blocker is compiled in when AM_DEMOD_DCBLOCK_EN is defined.
module am_envelope_demod #(
  parameter int unsigned LOG2_WIN = 6,
  parameter int unsigned DC_SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] AM_mod,
  output logic [15:0] demod_out,
  output logic        demod_valid,
  output logic        sat_flag
);

  localparam int unsigned ACC_W = 15 + LOG2_WIN;

  if (LOG2_WIN < 2 || LOG2_WIN > 10 || DC_SHIFT < 2 || DC_SHIFT > 12) begin : g_bad_param
    $error("am_envelope_demod: LOG2_WIN or DC_SHIFT out of range");
  end

  logic             is_min_c;
  logic [14:0]      abs_c;
  logic [14:0]      abs_r;
  logic             abs_v;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next_c;
  logic [LOG2_WIN-1:0] cnt;
  logic [14:0]      env_r;
  logic             dump_v;

  // -32768 has no positive 16-bit counterpart, so it clamps to full scale
  always_comb begin
    is_min_c   = (AM_mod == 16'h8000);
    abs_c      = AM_mod[15] ? 15'(16'd0 - AM_mod) : AM_mod[14:0];
    if (is_min_c) abs_c = 15'h7fff;
    acc_next_c = acc + ACC_W'(abs_r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abs_r    <= '0;
      abs_v    <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      abs_r <= abs_c;
      abs_v <= 1'b1;
      if (is_min_c) sat_flag <= 1'b1;
    end
  end

  // Dump folds the last sample straight into the result so windows abut seamlessly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      env_r  <= '0;
      dump_v <= 1'b0;
    end else if (abs_v) begin
      if (&cnt) begin
        env_r  <= 15'(acc_next_c >> LOG2_WIN);
        acc    <= '0;
        cnt    <= '0;
        dump_v <= 1'b1;
      end else begin
        acc    <= acc_next_c;
        cnt    <= cnt + LOG2_WIN'(1);
        dump_v <= 1'b0;
      end
    end else begin
      dump_v <= 1'b0;
    end
  end

`ifdef AM_DEMOD_DCBLOCK_EN
  localparam int unsigned DC_W = 15 + DC_SHIFT;

  logic [DC_W-1:0] dc_acc;
  logic [14:0]     dc_c;

  always_comb dc_c = 15'(dc_acc >> DC_SHIFT);

  // Leaky integrator tracks the carrier level; its estimate is subtracted each strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_acc      <= '0;
      demod_out   <= '0;
      demod_valid <= 1'b0;
    end else begin
      demod_valid <= dump_v;
      if (dump_v) begin
        demod_out <= {1'b0, env_r} - {1'b0, dc_c};
        dc_acc    <= dc_acc + DC_W'(env_r) - DC_W'(dc_c);
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      demod_out   <= '0;
      demod_valid <= 1'b0;
    end else begin
      demod_valid <= dump_v;
      if (dump_v) demod_out <= {1'b0, env_r};
    end
  end
`endif

endmodule

// File: tb/tb_am_envelope_demod.sv
// Self-checking bench for am_envelope_demod: window-sum reference model plus literal spot checks.
// Works for either build of AM_DEMOD_DCBLOCK_EN.
module tb_am_envelope_demod;

  localparam int unsigned LOG2_WIN = 6;
  localparam int unsigned DC_SHIFT = 8;
  localparam int WIN = 1 << LOG2_WIN;

  logic        clk;
  logic        rst;
  logic [15:0] AM_mod;
  logic [15:0] demod_out;
  logic        demod_valid;
  logic        sat_flag;

  int tests;
  int fails;
  bit started;

  am_envelope_demod #(.LOG2_WIN(LOG2_WIN), .DC_SHIFT(DC_SHIFT)) dut (
    .clk(clk), .rst(rst), .AM_mod(AM_mod),
    .demod_out(demod_out), .demod_valid(demod_valid), .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", name, $time, act, act, exp, exp);
    end
  endtask

  function automatic int rect(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  // Reference model: remembers every rectified sample since reset and averages whole windows
  int edge_n;
  int hist[$];
  longint m_dc_acc;
  int exp_out;
  bit exp_valid;
  bit exp_sat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_n = 0;
      hist.delete();
      m_dc_acc = 0;
      exp_out = 0;
      exp_valid = 0;
      exp_sat = 0;
    end else begin
      int sum;
      int env;
      int dc;
      edge_n++;
      hist.push_back(rect(AM_mod));
      if (AM_mod == 16'h8000) exp_sat = 1;
      exp_valid = (edge_n >= WIN + 2) && ((edge_n - 2) % WIN == 0);
      if (exp_valid) begin
        sum = 0;
        for (int e = edge_n - WIN - 1; e <= edge_n - 2; e++) sum += hist[e - 1];
        env = sum / WIN;
`ifdef AM_DEMOD_DCBLOCK_EN
        dc = int'(m_dc_acc / (64'd1 << DC_SHIFT));
        exp_out = env - dc;
        m_dc_acc = m_dc_acc + env - dc;
`else
        dc = 0;
        exp_out = env - dc;
`endif
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e16;
    if (started) begin
      e16 = 16'(exp_out);
      check("demod_valid", {31'd0, demod_valid}, {31'd0, exp_valid});
      check("demod_out", {16'd0, demod_out}, {16'd0, e16});
      check("sat_flag", {31'd0, sat_flag}, {31'd0, exp_sat});
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_out", {16'd0, demod_out}, 32'd0);
    check("rst_valid", {31'd0, demod_valid}, 32'd0);
    check("rst_sat", {31'd0, sat_flag}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] gen(input int mode, input int i);
    case (mode)
      0: return 16'd1000;
      1: return (i % 2 == 1) ? 16'd2000 : 16'(-2000);
      2: return (i == 10) ? 16'h8000 : 16'd0;
      3: return 16'($urandom);
      default: return ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
    endcase
  endfunction

  // Drives n samples starting at edge 1 after reset; literal checks pin the model
  task automatic run(input int mode, input int n);
    for (int i = 1; i <= n; i++) begin
      AM_mod = gen(mode, i);
      @(posedge clk);
      #1;
      if (i == WIN + 1) check("no_early_strobe", {31'd0, demod_valid}, 32'd0);
      if (i == WIN + 2) check("first_strobe", {31'd0, demod_valid}, 32'd1);
      if (i == WIN + 3) check("strobe_one_cycle", {31'd0, demod_valid}, 32'd0);
      if (i == 2 * WIN + 2) check("second_strobe", {31'd0, demod_valid}, 32'd1);
      if (i == WIN + 2 && mode == 0) check("const1000", {16'd0, demod_out}, 32'd1000);
      if (i == WIN + 2 && mode == 1) check("alt2000", {16'd0, demod_out}, 32'd2000);
      if (i == WIN + 2 && mode == 2) check("sat_env", {16'd0, demod_out}, 32'd511);
      if (i == 9 && mode == 2) check("sat_before", {31'd0, sat_flag}, 32'd0);
      if (i == 10 && mode == 2) check("sat_rise", {31'd0, sat_flag}, 32'd1);
      if (i == n && mode == 2) check("sat_sticky", {31'd0, sat_flag}, 32'd1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    started = 0;
    rst = 1'b1;
    AM_mod = '0;
    @(posedge clk);
    #1;
    started = 1;
    do_reset();
    run(0, 200);
    do_reset();
    run(1, WIN * 260);
    do_reset();
    run(2, 200);
    do_reset();
    run(3, WIN + 32);
    #2;
    do_reset();
    run(3, 300);
    do_reset();
    run(4, 3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/am_envelope_demod.md
# am_envelope_demod

Receive-side AM envelope demodulator. Consumes the signed 16-bit AM sample stream produced by the modulator stage (`AM_mod`) every clock. It full-wave rectifies the samples, then applies a boxcar integrate-and-dump low-pass with decimation by 2^LOG2_WIN. An optional DC blocker removes the carrier offset, recovering the baseband tone for loopback checking of the modulator chain.

## Interface
- LOG2_WIN, default 6: log2 of integrate-and-dump window length WIN (64 samples); legal range 2..10.
- DC_SHIFT, default 8: DC-blocker IIR time constant shift; legal range 2..12.

- clk  input  1  system clock; one AM sample per cycle.
- rst  input  1  asynchronous reset, active-high; one clock; all state cleared on assertion, released synchronously by design at top level.
- AM_mod  input  16  signed AM sample from modulator, sampled every rising edge.
- demod_out  output  16  signed recovered baseband (unsigned envelope zero-extended when DC block compiled out); reset 0.
- demod_valid  output  1  single-cycle strobe, demod_out updated this cycle; reset 0.
- sat_flag  output  1  sticky: an input of -32768 was rectified and saturated; reset 0; cleared only by rst.

## Operation
- Stage 1 (rectify):
  - abs_r <= |AM_mod| every cycle; -32768 maps to 32767 and sets sat_flag.
  - abs_v is 0 at reset, set at the first edge after release and held.
- Stage 2 (integrate-and-dump):
  - Active only when abs_v=1.
  - acc is unsigned, 15+LOG2_WIN bits, and never overflows.
  - cnt counts 0..WIN-1.
  - When cnt==WIN-1: sum_r <= acc+abs_r, acc <= 0, cnt <= 0, dump_v <= 1.
  - Otherwise: acc <= acc+abs_r, cnt <= cnt+1, dump_v <= 0.
  - Wrap is seamless: no sample is dropped or double-counted across windows.
- Stage 3 (output), on dump_v=1 only:
  - env = sum_r >> LOG2_WIN, unsigned 15-bit, range 0..32767.
  - With DC block: dc = dc_acc >> DC_SHIFT, where dc_acc is unsigned, 15+DC_SHIFT bits, reset 0.
  - demod_out <= env - dc, computed in 16-bit signed; range -32767..32767, so no saturation is needed.
  - dc_acc <= dc_acc + env - dc, using the pre-update dc.
  - demod_valid <= 1 for exactly one cycle.
- demod_out holds its value between strobes.
- Reset mid-window: acc, cnt, abs_v, dump_v, dc_acc, outputs and sat_flag all clear immediately; the partial window is discarded.

## Timing
- Edge numbering: edge 1 is the first rising edge after rst deasserts.
- The first window covers samples captured at edges 1..WIN.
- dump_v is high after edge WIN+1.
- First demod_valid is high after edge WIN+2.
- Steady state: demod_valid pulses once every WIN cycles exactly, at edges WIN+2+k·WIN.
- Latency from the last sample of a window to its strobe is 2 cycles.
- Throughput: one input per clock with no back-pressure; the block has no stall path.

## Configuration
- Macro AM_DEMOD_DCBLOCK_EN:
  - Defined: Stage 3 DC blocker is present as described.
  - Undefined: dc_acc logic is removed and demod_out <= {1'b0, env}, i.e. the raw envelope, always ≥0.
- Strobe timing, sat_flag and all other behaviour are identical in both builds.

## Test plan
- Constant AM_mod=1000, DC block off, defaults: first demod_valid after edge 66, demod_out=1000, then one strobe every 64 cycles.
- Alternating +2000/-2000 each cycle: envelope 2000. DC block off gives demod_out=2000. DC block on gives first output 2000, then the output decays monotonically toward 0; dc reaches ≥1264 (63% of 2000) within 256 strobes.
- Single AM_mod=-32768 sample among zeros: sat_flag rises after edge 1 of that sample and stays 1; that window's env = 32767>>6 = 511.
- rst asserted at cnt=30 of a window with nonzero data: outputs immediately 0. After release, the next demod_valid comes after edge 66 and reflects only post-reset samples.
- Loopback with the modulator, 100 kHz tone on 1 MHz carrier, DC block on, LOG2_WIN=3: demod_out is a sinusoid at 100 kHz with zero mean ±2% of peak after settling, and has no strobe gaps.
